matvec2_seq: RTL and testbench

Sequential 2x2 matrix-vector multiply stage sitting directly downstream of the 2x2 matrix inverter. It takes the four inverse-matrix words and the inverter's error code, plus a 2-element vector, and produces x = M·v using one shared multiplier over four cycles. Input and output use valid/ready handshakes. A non-zero error code bypasses the arithmetic and is forwarded unchanged.

---
 rtl/matvec2_pkg.sv | 15 +
 rtl/matvec2_seq_mac_step.sv | 17 +
 rtl/matvec2_seq.sv | 129 ++++++++++++
 tb/tb_matvec2_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/matvec2_pkg.sv
// Shared types and constants for the sequential 2x2 matrix-vector multiply stage.
package matvec2_pkg;

  localparam int          STEPS    = 4;
  localparam logic [1:0]  ERR_NONE = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

endpackage

// File: rtl/matvec2_seq_mac_step.sv
// One multiply-accumulate step: low-W product of a and b added to acc, all modulo 2^W.
module mac_step #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] acc_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] prod;

  // Self-determined W-bit multiply keeps exactly the low W bits of the product.
  assign prod  = W'(a_i * b_i);
  assign sum_o = acc_i + prod;

endmodule

// File: rtl/matvec2_seq.sv
// 2x2 matrix-vector multiply x = M*v over four cycles using one shared multiplier;
// a non-zero inverter error code bypasses the arithmetic and is forwarded.
module matvec2_seq
  import matvec2_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   m0,
  input  logic [DATA_WIDTH:0]   m1,
  input  logic [DATA_WIDTH:0]   m2,
  input  logic [DATA_WIDTH:0]   m3,
  input  logic [1:0]            err_in,
  input  logic [DATA_WIDTH:0]   v0,
  input  logic [DATA_WIDTH:0]   v1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH:0]   x0,
  output logic [DATA_WIDTH:0]   x1,
  output logic [1:0]            err_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int W = DATA_WIDTH + 1;

  state_t               state_q,  state_d;
  step_t                step_q,   step_d;
  logic [3:0][W-1:0]    m_q,      m_d;
  logic [1:0][W-1:0]    v_q,      v_d;
  logic [1:0]           err_q,    err_d;
  logic [W-1:0]         acc_q,    acc_d;
  logic [W-1:0]         x0_q,     x0_d;
  logic [W-1:0]         x1_q,     x1_d;

  logic [W-1:0]         mac_a;
  logic [W-1:0]         mac_b;
  logic [W-1:0]         mac_sum;

  // Step order m0*v0, m1*v1, m2*v0, m3*v1: matrix word follows the step, vector word its LSB.
  assign mac_a = m_q[step_q];
  assign mac_b = v_q[step_q[0]];

  mac_step #(.W(W)) u_mac (
    .a_i   (mac_a),
    .b_i   (mac_b),
    .acc_i (acc_q),
    .sum_o (mac_sum)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latches).
    state_d = state_q;
    step_d  = step_q;
    m_d     = m_q;
    v_d     = v_q;
    err_d   = err_q;
    acc_d   = acc_q;
    x0_d    = x0_q;
    x1_d    = x1_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = {m3, m2, m1, m0};
          v_d     = {v1, v0};
          err_d   = err_in;
          acc_d   = '0;
          step_d  = '0;
          x0_d    = '0;
          x1_d    = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // An errored matrix spends one cycle here so its response appears one edge after acceptance.
        if (err_q != ERR_NONE) begin
          state_d = OUT;
        end else begin
          acc_d  = mac_sum;
          step_d = step_q + 2'd1;
          if (step_q == 2'd1) begin
            x0_d  = mac_sum;
            acc_d = '0;
          end
          if (step_q == 2'(STEPS - 1)) begin
            x1_d    = mac_sum;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      m_q     <= '0;
      v_q     <= '0;
      err_q   <= ERR_NONE;
      acc_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      m_q     <= m_d;
      v_q     <= v_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == OUT);
  assign x0        = x0_q;
  assign x1        = x1_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_matvec2_seq.sv
// Randomized scoreboard bench for matvec2_seq: expected results are queued at acceptance
// and popped by an independent monitor whenever an output transfer happens.
module tb_matvec2_seq;

  localparam int DW = 8;
  localparam int W  = DW + 1;
  localparam int MASK = (1 << W) - 1;

  typedef struct {
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    logic [1:0]   err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] m0 = '0, m1 = '0, m2 = '0, m3 = '0, v0 = '0, v1 = '0;
  logic [1:0]   err_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x0, x1;
  logic [1:0]   err_out;
  logic         out_valid;
  logic         out_ready = 1'b1;

  int checks   = 0;
  int failures = 0;
  int ready_mode = 0;  // 0 always ready, 1 random, 3 manual
  exp_t sb_q[$];

  matvec2_seq #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0),
    .m1        (m1),
    .m2        (m2),
    .m3        (m3),
    .err_in    (err_in),
    .v0        (v0),
    .v1        (v1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .x1        (x1),
    .err_out   (err_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic reduced modulo 2^W.
  function automatic exp_t model(input int a0, a1, a2, a3, b0, b1, input logic [1:0] e);
    exp_t r;
    if (e != 2'b00) begin
      r.x0 = '0; r.x1 = '0; r.err = e;
    end else begin
      r.x0  = W'((a0 * b0 + a1 * b1) & MASK);
      r.x1  = W'((a2 * b0 + a3 * b1) & MASK);
      r.err = 2'b00;
    end
    return r;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (ready_mode == 0)      out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops on every transfer and checks outputs stay stable while stalled.
  logic         prev_valid = 1'b0, prev_xfer = 1'b0;
  logic [W-1:0] prev_x0, prev_x1;
  logic [1:0]   prev_err;
  always begin
    @(negedge clk);
    if (rst) begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_low_in_out", 32'(in_ready), 32'd0);
        if (prev_valid && !prev_xfer) begin
          check("hold_x0", 32'(x0), 32'(prev_x0));
          check("hold_x1", 32'(x1), 32'(prev_x1));
          check("hold_err", 32'(err_out), 32'(prev_err));
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("x0", 32'(x0), 32'(e.x0));
            check("x1", 32'(x1), 32'(e.x1));
            check("err_out", 32'(err_out), 32'(e.err));
          end
        end
      end
      prev_valid = out_valid;
      prev_xfer  = out_valid && out_ready;
      prev_x0    = x0;
      prev_x1    = x1;
      prev_err   = err_out;
    end
  end

  // Present a transaction, wait for acceptance, queue its expectation, then scramble the inputs.
  task automatic accept(input int a0, a1, a2, a3, b0, b1, input logic [1:0] e);
    bit got = 0;
    m0 = W'(a0); m1 = W'(a1); m2 = W'(a2); m3 = W'(a3);
    v0 = W'(b0); v1 = W'(b1); err_in = e;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
    end
    if (!got) begin
      check("accept_timeout", 32'd1, 32'd0);
    end else begin
      sb_q.push_back(model(a0, a1, a2, a3, b0, b1, e));
    end
    #1;
    in_valid = 1'b0;
    m0 = W'($urandom); m1 = W'($urandom); m2 = W'($urandom); m3 = W'($urandom);
    v0 = W'($urandom); v1 = W'($urandom); err_in = 2'($urandom);
  endtask

  // Full transaction plus a check of the acceptance-to-out_valid latency (edges counted).
  task automatic send(input int a0, a1, a2, a3, b0, b1, input logic [1:0] e);
    int lat = -1;
    accept(a0, a1, a2, a3, b0, b1, e);
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
    end
    check(e != 2'b00 ? "latency_err" : "latency_norm", 32'(lat), (e != 2'b00) ? 32'd1 : 32'd4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_x0", 32'(x0), 32'd0);
    check("rst_x1", 32'(x1), 32'd0);
    check("rst_err", 32'(err_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    send(1, 2, 3, 4, 5, 6, 2'b00);
    send(300, 0, 511, 1, 2, 3, 2'b00);
    send(17, 99, 250, 7, 33, 444, 2'b01);
    send(5, 5, 5, 5, 5, 5, 2'b11);

    // Backpressure with ignored in_valid pulses.
    ready_mode = 3;
    out_ready  = 1'b0;
    send(9, 8, 7, 6, 5, 4, 2'b00);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      m0 = W'($urandom); v0 = W'($urandom);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Reset while at step 2: the result is discarded.
    accept(1, 2, 3, 4, 5, 6, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    void'(sb_q.pop_back());
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_x0", 32'(x0), 32'd0);
    check("midrst_x1", 32'(x1), 32'd0);
    check("midrst_err", 32'(err_out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(1, 2, 3, 4, 5, 6, 2'b00);

    // Randomized traffic with random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      logic [1:0] e;
      e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send(int'(W'($urandom)), int'(W'($urandom)), int'(W'($urandom)), int'(W'($urandom)),
           int'(W'($urandom)), int'(W'($urandom)), e);
    end
    ready_mode = 0;

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
